// File: rtl/fp_operand_unpack.sv
// Two-stage elastic operand decoder: S1 captures the raw operand pair, S2 holds the
// decoded sign/exponent/mantissa/class fields that feed the multiply/divide datapath.
module fp_operand_unpack #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic               en,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   input  logic               op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               s_a,
   output logic               s_b,
   output logic [EXP_W-1:0]   e_a,
   output logic [EXP_W-1:0]   e_b,
   output logic [MAN_W:0]     m_a,
   output logic [MAN_W:0]     m_b,
   output logic               zero_a,
   output logic               sub_a,
   output logic               inf_a,
   output logic               nan_a,
   output logic               zero_b,
   output logic               sub_b,
   output logic               inf_b,
   output logic               nan_b,
   output logic               op_q
);

   localparam int W = 1 + EXP_W + MAN_W;

   logic [1:0][W-1:0]     opnd_q;
   logic                  op1_q;
   logic                  v1_q;
   logic                  v2_q;

   logic [1:0]            sign_q;
   logic [1:0][EXP_W-1:0] exp_q;
   logic [1:0][EXP_W-1:0] exp_d;
   logic [1:0][MAN_W:0]   man_q;
   logic [1:0][MAN_W:0]   man_d;
   logic [1:0][3:0]       cls_q;
   logic [1:0][3:0]       cls_d;
   logic                  op2_q;

   logic                  s1_load;
   logic                  s2_load;

   assign s2_load  = en & v1_q & (~v2_q | out_ready);
   assign in_ready = en & (~v1_q | s2_load);
   assign s1_load  = en & in_valid & in_ready;

   // Index 0 decodes operand a, index 1 decodes operand b; class bits are {zero, sub, inf, nan}.
   for (genvar gi = 0; gi < 2; gi++) begin : g_dec
      logic [EXP_W-1:0] fexp;
      logic [MAN_W-1:0] frac;
      logic             exp_zero;
      logic             exp_ones;
      logic             frac_nz;

      assign fexp     = opnd_q[gi][W-2 -: EXP_W];
      assign frac     = opnd_q[gi][MAN_W-1:0];
      assign exp_zero = (fexp == '0);
      assign exp_ones = &fexp;
      assign frac_nz  = |frac;

      // Subnormals share the exponent of the smallest normal, so report 1 rather than 0.
      assign exp_d[gi] = (exp_zero & frac_nz) ? EXP_W'(1) : fexp;
      assign man_d[gi] = {~exp_zero, frac};
      assign cls_d[gi] = {exp_zero & ~frac_nz, exp_zero & frac_nz,
                          exp_ones & ~frac_nz, exp_ones & frac_nz};
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         opnd_q <= '0;
         op1_q  <= 1'b0;
         v1_q   <= 1'b0;
      end else begin
         if (s1_load) begin
            opnd_q <= {b, a};
            op1_q  <= op;
            v1_q   <= 1'b1;
         end else if (s2_load) begin
            v1_q   <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         sign_q <= '0;
         exp_q  <= '0;
         man_q  <= '0;
         cls_q  <= '0;
         op2_q  <= 1'b0;
         v2_q   <= 1'b0;
      end else begin
         if (s2_load) begin
            sign_q <= {opnd_q[1][W-1], opnd_q[0][W-1]};
            exp_q  <= exp_d;
            man_q  <= man_d;
            cls_q  <= cls_d;
            op2_q  <= op1_q;
            v2_q   <= 1'b1;
         end else if (en && out_ready) begin
            v2_q   <= 1'b0;
         end
      end
   end

   assign out_valid = v2_q;
   assign op_q      = op2_q;
   assign s_a       = sign_q[0];
   assign s_b       = sign_q[1];
   assign e_a       = exp_q[0];
   assign e_b       = exp_q[1];
   assign m_a       = man_q[0];
   assign m_b       = man_q[1];
   assign zero_a    = cls_q[0][3];
   assign sub_a     = cls_q[0][2];
   assign inf_a     = cls_q[0][1];
   assign nan_a     = cls_q[0][0];
   assign zero_b    = cls_q[1][3];
   assign sub_b     = cls_q[1][2];
   assign inf_b     = cls_q[1][1];
   assign nan_b     = cls_q[1][0];

endmodule

// File: tb/tb_fp_operand_unpack.sv
// Scoreboard bench for fp_operand_unpack: stimulus pushes expected decodes at accept time,
// an independent monitor pops and compares at each output handshake and checks hold stability.
module tb_fp_operand_unpack;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int OW    = 75;

   logic        clk = 1'b0;
   logic        arst_n, en, in_valid, in_ready, op, out_valid, out_ready;
   logic [31:0] a, b;
   logic        s_a, s_b, zero_a, sub_a, inf_a, nan_a, zero_b, sub_b, inf_b, nan_b, op_q;
   logic [7:0]  e_a, e_b;
   logic [23:0] m_a, m_b;
   logic [OW-1:0] out_vec;

   int errors = 0;
   int checks = 0;
   logic [OW-1:0] exp_q[$];

   fp_operand_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk(clk), .arst_n(arst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .s_a(s_a), .s_b(s_b), .e_a(e_a), .e_b(e_b), .m_a(m_a), .m_b(m_b),
      .zero_a(zero_a), .sub_a(sub_a), .inf_a(inf_a), .nan_a(nan_a),
      .zero_b(zero_b), .sub_b(sub_b), .inf_b(inf_b), .nan_b(nan_b), .op_q(op_q)
   );

   always #5 clk = ~clk;

   assign out_vec = {op_q, s_a, e_a, m_a, zero_a, sub_a, inf_a, nan_a,
                     s_b, e_b, m_b, zero_b, sub_b, inf_b, nan_b};

   // Reference decode straight from the IEEE-754 class rules.
   function automatic logic [36:0] ref_dec(input logic [31:0] x);
      int unsigned ex, fr, e, m;
      logic z, s, i, n;
      ex = x[30:23];
      fr = x[22:0];
      z  = (ex == 0)   && (fr == 0);
      s  = (ex == 0)   && (fr != 0);
      i  = (ex == 255) && (fr == 0);
      n  = (ex == 255) && (fr != 0);
      e  = s ? 1 : ex;
      m  = (ex == 0) ? fr : fr + (1 << 23);
      return {x[31], e[7:0], m[23:0], z, s, i, n};
   endfunction

   function automatic logic [31:0] rand_opnd();
      logic        sg;
      logic [7:0]  ex;
      logic [22:0] fr;
      sg = 1'($urandom);
      fr = 23'($urandom);
      case ($urandom_range(0, 5))
         0:       begin ex = 8'h00; fr = '0; end
         1:       begin ex = 8'h00; if (fr == 0) fr = 23'd1; end
         2:       begin ex = 8'hFF; fr = '0; end
         3:       begin ex = 8'hFF; if (fr == 0) fr = 23'd5; end
         default: ex = 8'($urandom_range(1, 254));
      endcase
      return {sg, ex, fr};
   endfunction

   task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic drive_rand(input logic v);
      a        = rand_opnd();
      b        = rand_opnd();
      op       = 1'($urandom);
      in_valid = v;
   endtask

   // One clock of stimulus: record the accept (if any) then move to just after the edge.
   task automatic step(output bit acc);
      @(negedge clk);
      acc = arst_n && in_valid && in_ready;
      if (acc) exp_q.push_back({op, ref_dec(a), ref_dec(b)});
      @(posedge clk);
      #1;
   endtask

   task automatic send_dir(input logic [31:0] av, input logic [31:0] bv, input logic opv,
                           input logic [OW-1:0] expv);
      a = av; b = bv; op = opv; in_valid = 1'b1;
      @(negedge clk);
      chk("dir_in_ready", OW'(in_ready), OW'(1));
      if (in_ready) exp_q.push_back(expv);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      bit acc;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      en        = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 20) begin
         step(acc);
         n++;
      end
      chk("drain_empty", OW'(exp_q.size()), OW'(0));
   endtask

   // Monitor: pops at every output handshake, and requires outputs to hold whenever the
   // previous cycle presented a result that was not taken.
   logic [OW-1:0] prev_vec;
   bit            hold_pend = 0;
   always @(negedge clk) begin
      if (!arst_n) begin
         hold_pend = 0;
      end else begin
         if (hold_pend) chk("hold_stable", out_vec, prev_vec);
         if (out_valid && en && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %h required none", out_vec);
            end else begin
               $display("result %h", out_vec);
               chk("result", out_vec, exp_q.pop_front());
            end
         end
         hold_pend = out_valid && !(en && out_ready);
         prev_vec  = out_vec;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int cnt, n;
      arst_n = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; op = 1'b0;
      #1;
      chk("reset_out_valid", OW'(out_valid), OW'(0));
      chk("reset_outputs", out_vec, '0);
      #11 arst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_in_ready", OW'(in_ready), OW'(1));
      en = 1'b0;
      #1 chk("en_low_in_ready", OW'(in_ready), OW'(0));
      en = 1'b1;

      send_dir(32'h3FC00000, 32'hC0000000, 1'b0,
               {1'b0, 1'b0, 8'h7F, 24'hC00000, 4'b0000, 1'b1, 8'h80, 24'h800000, 4'b0000});
      send_dir(32'h00000001, 32'h7FC00000, 1'b1,
               {1'b1, 1'b0, 8'h01, 24'h000001, 4'b0100, 1'b0, 8'hFF, 24'hC00000, 4'b0001});
      send_dir(32'h80000000, 32'hFF800000, 1'b0,
               {1'b0, 1'b1, 8'h00, 24'h000000, 4'b1000, 1'b1, 8'hFF, 24'h800000, 4'b0010});
      drain();

      // Backpressure: two accepts fill the pipe, the third is refused until out_ready returns.
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive_rand(1'b1);
         step(acc);
         chk("bp_accept", OW'(acc), OW'(1));
      end
      drive_rand(1'b1);
      step(acc);
      chk("bp_full_refuse", OW'(acc), OW'(0));
      out_ready = 1'b1;
      cnt = 2; n = 0;
      while (cnt < 4 && n < 10) begin
         step(acc);
         if (acc) begin
            cnt++;
            drive_rand(1'b1);
         end
         n++;
      end
      chk("bp_accept_count", OW'(cnt), OW'(4));
      drain();

      // Enable freeze with two pairs in flight.
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive_rand(1'b1);
         step(acc);
      end
      drive_rand(1'b1);
      out_ready = 1'b1;
      en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("freeze_in_ready", OW'(in_ready), OW'(0));
         chk("freeze_out_valid", OW'(out_valid), OW'(1));
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      drain();

      // Reset while both stages hold data.
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive_rand(1'b1);
         step(acc);
      end
      in_valid = 1'b0;
      #2 arst_n = 1'b0;
      #1;
      chk("mid_reset_out_valid", OW'(out_valid), OW'(0));
      chk("mid_reset_outputs", out_vec, '0);
      exp_q.delete();
      @(negedge clk);
      #2 arst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_reset_quiet", OW'(out_valid), OW'(0));
      end
      @(posedge clk);
      #1;

      // Randomised traffic with random backpressure and enable gaps.
      for (int i = 0; i < 400; i++) begin
         drive_rand(($urandom % 10) < 7);
         out_ready = ($urandom % 10) < 7;
         en        = ($urandom % 10) < 9;
         step(acc);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fp_operand_unpack.md
# fp_operand_unpack

Front-end operand decoder for the floating-point multiply/divide datapath. It accepts two IEEE-754 binary operands plus an operation select through a valid/ready handshake and splits each operand into sign, biased exponent and mantissa with the hidden bit restored. It classifies each operand as zero, subnormal, infinity or NaN. Results come out of a 2-stage elastic pipeline that feeds the sign, exponent and mantissa units downstream.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, stored fraction width (IEEE-754 single precision by default)
- clk  in  1  rising-edge clock
- arst_n  in  1  asynchronous, active-low reset
- en  in  1  global pipeline enable; low freezes all state
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept operands this cycle
- a, b  in  1+EXP_W+MAN_W  raw operands, {sign, exponent, fraction}
- op  in  1  0 = multiply, 1 = divide; passed through aligned
- out_valid  out  1  decoded result present
- out_ready  in  1  downstream accepts result
- s_a, s_b  out  1  operand signs
- e_a, e_b  out  EXP_W  effective biased exponents
- m_a, m_b  out  MAN_W+1  mantissas with hidden bit
- zero_a, sub_a, inf_a, nan_a; zero_b, sub_b, inf_b, nan_b  out  1 each  class flags
- op_q  out  1  registered op

## Operation
- Stage 1 (S1) registers a, b and op, plus valid flag v1.
- Stage 2 (S2) registers the decoded fields and flags, plus valid flag v2; all outputs come directly from S2 registers.
- Decode rules, per operand:
  - exp == 0, frac == 0: zero=1, e=0, m=0.
  - exp == 0, frac != 0: sub=1, e=1 (effective exponent), m={1'b0, frac}.
  - exp all-ones, frac == 0: inf=1, e=exp, m={1'b1, frac}.
  - exp all-ones, frac != 0: nan=1, e=exp, m={1'b1, frac}.
  - Otherwise normal: e=exp, m={1'b1, frac}.
  - Exactly one or zero flags are set per operand.
  - Sign passes through unchanged for every class, including NaN.
- Stage load conditions:
  - s2_load = en & v1 & (!v2 | out_ready)
  - s1_load = en & in_valid & in_ready
  - in_ready = en & (!v1 | s2_load)
- v2 update when en:
  - Set on s2_load.
  - Cleared when out_ready & !s2_load.
- v1 update when en:
  - Set on s1_load.
  - Cleared when s2_load & !s1_load.
- en low: every register holds, in_ready=0; out_valid and outputs hold their values.
- Simultaneous accept at S1 and drain at S2 in the same cycle gives full throughput, one pair per cycle.

## Timing
- Reset (arst_n low, asynchronous): v1=v2=0, all S1/S2 data registers 0. Therefore out_valid=0, all outputs 0, op_q=0. in_ready=en immediately after reset.
- Latency: operands accepted at edge N appear on outputs with out_valid=1 after edge N+1, i.e. 2 cycles.
- Throughput: 1 per cycle while out_ready=1 and en=1.
- Backpressure:
  - out_ready low with v2=1: S2 holds its data stable.
  - S1 still accepts one more pair if v1=0; in_ready then falls.
  - Capacity is 2 pairs in flight.
  - While out_valid=1 and out_ready=0, the outputs must not change.
- in_ready is combinational from en, v1, v2 and out_ready; there is no combinational path from in_valid to in_ready.
- Reset asserted mid-stream: in-flight data is discarded; nothing is emitted after reset release until new operands are accepted.

## Test plan
- Normal operands: a=0x3FC00000 (1.5), b=0xC0000000 (−2.0), op=0. After 2 cycles:
  - s_a=0, e_a=0x7F, m_a=0xC00000
  - s_b=1, e_b=0x80, m_b=0x800000
  - all flags 0, op_q=0
- Specials: a=0x00000001, b=0x7FC00000, op=1. Required:
  - sub_a=1, e_a=1, m_a=0x000001
  - nan_b=1, e_b=0xFF, m_b=0xC00000
  - op_q=1
- Zero/inf with signs: a=0x80000000, b=0xFF800000. Required:
  - zero_a=1, s_a=1, m_a=0
  - inf_b=1, s_b=1, m_b=0x800000
- Backpressure: stream 4 pairs back-to-back with out_ready held 0 for 3 cycles. Required:
  - in_ready drops after 2 accepts.
  - Outputs stay stable while held.
  - All 4 results emerge in order, with no loss or duplication.
- Enable freeze: deassert en for 2 cycles with 2 pairs in flight. Required: outputs, out_valid and state hold, in_ready=0; the stream resumes intact when en returns.
- Reset mid-stream: pull arst_n low while v1=v2=1. Required: out_valid=0 and outputs=0 immediately (asynchronously); no stale result appears after release.
